// File: rtl/cnn_stream_pkg.sv
// ---------------------------------------------------------------------------
// cnn_stream_pkg
// Shared definitions for the CNN frame streamer: FSM state encoding, frame
// geometry for the default 28x28 configuration, the decision width, the
// result code reported on a timeout, and a counter-width helper.
// ---------------------------------------------------------------------------
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_DONE     = 2'd3
    } stream_state_t;

    localparam int DEFAULT_IMG_W = 28;
    localparam int DEFAULT_IMG_H = 28;
    localparam int FRAME_PIXELS  = DEFAULT_IMG_W * DEFAULT_IMG_H;

    localparam int DECISION_BITS = 4;
    localparam logic [DECISION_BITS-1:0] RESULT_TIMEOUT_CODE = 4'hF;

    // Bits needed to hold 0..max_value, never less than one so that a
    // degenerate counter (for example a zero-length gap) still has a legal width.
    function automatic int counter_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_ram_sp.sv
// ---------------------------------------------------------------------------
// frame_ram_sp
// Single-port synchronous frame RAM, DATA_BITS x 2^ADDR_BITS. It has one
// shared address for reads and writes. A write returns the written data on
// the read port in the same cycle (write-first). Contents are not reset.
//
// Ports:
//   i_clk    clock
//   i_we     write enable for i_addr
//   i_addr   shared read/write address
//   i_wdata  write data
//   o_rdata  registered read data (one cycle after i_addr)
// ---------------------------------------------------------------------------
module frame_ram_sp
    import cnn_stream_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
)
(
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_wdata,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/cnn_frame_streamer.sv
// ---------------------------------------------------------------------------
// cnn_frame_streamer
// Transmit-side driver for the CNN pixel-stream interface. The host loads one
// IMG_W x IMG_H frame into the internal RAM and then pulses start. The block
// streams the pixels in raster order, optionally with GAP_CYCLES idle cycles
// after each pixel. It then waits up to TIMEOUT cycles for the CNN decision
// and reports the class, or 4'hF on a timeout.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wr_en/addr/data     host frame-RAM write port (accepted only while ready)
//   i_start               single-cycle start pulse (accepted only while ready)
//   o_ready               high in IDLE/DONE
//   o_pixel_out/valid     pixel stream to CNN data_in/valid_in
//   i_cnn_valid/decision  decision returned by the CNN
//   o_result_valid        one-cycle pulse when o_result is updated
//   o_result              last class, 4'hF on timeout
//   o_timeout_err         last run timed out (held in DONE)
//   o_proto_err           sticky: CNN answered outside WAIT_RES
//
// Requires 2^ADDR_BITS >= IMG_W*IMG_H.
// ---------------------------------------------------------------------------
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int DATA_BITS  = 8,
    parameter int ADDR_BITS  = 10,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 4096
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [ADDR_BITS-1:0]     i_wr_addr,
    input  logic [DATA_BITS-1:0]     i_wr_data,
    input  logic                     i_start,
    output logic                     o_ready,
    output logic [DATA_BITS-1:0]     o_pixel_out,
    output logic                     o_pixel_valid,
    input  logic                     i_cnn_valid,
    input  logic [DECISION_BITS-1:0] i_cnn_decision,
    output logic                     o_result_valid,
    output logic [DECISION_BITS-1:0] o_result,
    output logic                     o_timeout_err,
    output logic                     o_proto_err
);

    localparam int GAP_W  = counter_width(GAP_CYCLES);
    localparam int WAIT_W = counter_width(TIMEOUT);

    localparam logic [31:0]          LP_FRAME      = 32'(IMG_W * IMG_H);
    localparam logic [ADDR_BITS-1:0] LP_LAST_ADDR  = ADDR_BITS'(IMG_W * IMG_H - 1);
    localparam logic [GAP_W-1:0]     LP_GAP_RELOAD = GAP_W'(GAP_CYCLES);
    localparam logic [WAIT_W-1:0]    LP_WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    stream_state_t              r_state;
    stream_state_t              w_state_next;
    logic [ADDR_BITS-1:0]       r_pix_cnt;
    logic [ADDR_BITS-1:0]       w_pix_cnt_next;
    logic [GAP_W-1:0]           r_gap_cnt;
    logic [GAP_W-1:0]           w_gap_cnt_next;
    logic [WAIT_W-1:0]          r_wait_cnt;
    logic [WAIT_W-1:0]          w_wait_cnt_next;

    logic                       w_wr_ok;
    logic                       w_start_ok;
    logic                       w_issue;
    logic                       w_result_valid_next;
    logic [DECISION_BITS-1:0]   w_result_next;
    logic                       w_timeout_next;

    logic [ADDR_BITS-1:0]       w_ram_addr;
    logic [DATA_BITS-1:0]       w_ram_rdata;
    logic                       r_rd_issue;

    // o_ready is registered. Right after reset the FSM is already in IDLE
    // while o_ready is still 0, so a start or write in that cycle is dropped.
    // The write range check is done at 32 bits so that a RAM sized exactly
    // to the frame still compares correctly.
    always_comb begin
        w_wr_ok    = o_ready && i_wr_en && (32'(i_wr_addr) < LP_FRAME);
        w_start_ok = o_ready && i_start;
        w_ram_addr = w_wr_ok ? i_wr_addr : r_pix_cnt;
    end

    // Next-state logic. In STREAM a zero gap counter means an address is
    // issued this cycle. After the last address the FSM moves straight to
    // WAIT_RES, and the read pipeline still delivers that final pixel. In
    // WAIT_RES a decision takes priority over a timeout in the same cycle.
    always_comb begin
        w_state_next        = r_state;
        w_pix_cnt_next      = r_pix_cnt;
        w_gap_cnt_next      = r_gap_cnt;
        w_wait_cnt_next     = r_wait_cnt;
        w_issue             = 1'b0;
        w_result_valid_next = 1'b0;
        w_result_next       = o_result;
        w_timeout_next      = o_timeout_err;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state_next   = ST_STREAM;
                    w_pix_cnt_next = '0;
                    w_gap_cnt_next = '0;
                    w_timeout_next = 1'b0;
                end
            end
            ST_STREAM: begin
                if (r_gap_cnt == '0) begin
                    w_issue = 1'b1;
                    if (r_pix_cnt == LP_LAST_ADDR) begin
                        w_state_next    = ST_WAIT_RES;
                        w_wait_cnt_next = '0;
                    end else begin
                        w_pix_cnt_next = r_pix_cnt + 1'b1;
                        w_gap_cnt_next = LP_GAP_RELOAD;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 1'b1;
                end
            end
            ST_WAIT_RES: begin
                if (i_cnn_valid) begin
                    w_state_next        = ST_DONE;
                    w_result_next       = i_cnn_decision;
                    w_result_valid_next = 1'b1;
                    w_timeout_next      = 1'b0;
                end else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_state_next        = ST_DONE;
                    w_result_next       = RESULT_TIMEOUT_CODE;
                    w_result_valid_next = 1'b1;
                    w_timeout_next      = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and the result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_pix_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_wait_cnt     <= '0;
            o_ready        <= 1'b0;
            o_result_valid <= 1'b0;
            o_result       <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pix_cnt      <= w_pix_cnt_next;
            r_gap_cnt      <= w_gap_cnt_next;
            r_wait_cnt     <= w_wait_cnt_next;
            o_ready        <= (w_state_next == ST_IDLE) || (w_state_next == ST_DONE);
            o_result_valid <= w_result_valid_next;
            o_result       <= w_result_next;
            o_timeout_err  <= w_timeout_next;
        end
    end

    // Pixel pipeline: the address is issued in cycle N, the RAM data is
    // available after edge N+1, and it is registered onto the stream at
    // edge N+2. During gaps the RAM keeps reading, but o_pixel_out holds
    // the last pixel sent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_issue    <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_pixel_out   <= '0;
            o_proto_err   <= 1'b0;
        end else begin
            r_rd_issue    <= w_issue;
            o_pixel_valid <= r_rd_issue;
            if (r_rd_issue) begin
                o_pixel_out <= w_ram_rdata;
            end
            o_proto_err <= o_proto_err | (i_cnn_valid & (r_state != ST_WAIT_RES));
        end
    end

    frame_ram_sp #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_frame_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok),
        .i_addr  (w_ram_addr),
        .i_wdata (i_wr_data),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: doc/cnn_frame_streamer.md
Name: cnn_frame_streamer

Overview:
Transmit-side driver for the CNN pixel-stream interface (8-bit pixel plus valid, 4-bit decision plus valid back). A host loads one 28x28 frame into an internal byte RAM, then pulses start. The block streams the pixels in raster order into the CNN data_in/valid_in and waits for the returned decision. It reports the class, or a timeout, to the host. It sits between the host/testbench load port and the CNN top.

Parameters:
IMG_W, 28, frame width in pixels
IMG_H, 28, frame height in pixels
DATA_BITS, 8, pixel width
ADDR_BITS, 10, frame RAM address width (must satisfy 2^ADDR_BITS >= IMG_W*IMG_H)
GAP_CYCLES, 0, idle cycles inserted after every pixel (0 = back-to-back)
TIMEOUT, 4096, maximum cycles allowed in WAIT_RES before a timeout is declared

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  host frame-RAM write strobe
wr_addr  in  ADDR_BITS  raster pixel index
wr_data  in  DATA_BITS  pixel value
start  in  1  single-cycle pulse: stream the stored frame
ready  out  1  high in IDLE/DONE; start is accepted only when ready=1
pixel_out  out  DATA_BITS  pixel to CNN data_in
pixel_valid  out  1  to CNN valid_in
cnn_valid  in  1  CNN valid_out
cnn_decision  in  4  CNN decision
result_valid  out  1  single-cycle pulse when the result is updated
result  out  4  last class; 4'hF on timeout
timeout_err  out  1  high while in DONE if the last run timed out
proto_err  out  1  sticky; set when cnn_valid arrives outside WAIT_RES; cleared by reset only

Behaviour:
- Reset (sync, active-high) clears all outputs to 0: ready, pixel_out, pixel_valid, result_valid, result, timeout_err, proto_err. State goes to IDLE and counters to 0. RAM contents are not cleared.
- A reset asserted mid-stream forces pixel_valid=0 at the next edge. No partial-frame recovery.
- FSM states: IDLE, STREAM, WAIT_RES, DONE.
- IDLE: when start=1, go to STREAM, clear pix_cnt/gap_cnt, clear timeout_err.
- STREAM: issue RAM read address pix_cnt. RAM read is synchronous (1 cycle), so pixel_out/pixel_valid are registered one cycle after the address.
  - The first pixel_valid=1 occurs exactly 2 cycles after the edge that samples start.
  - GAP_CYCLES=0: pixel_valid stays high for exactly IMG_W*IMG_H (784) consecutive cycles, pixels in addresses 0..783.
  - GAP_CYCLES=g: each valid cycle is followed by g cycles with pixel_valid=0. pixel_out holds its last value during gaps.
  - After the last address is issued, go to WAIT_RES. The final pixel_valid is still emitted on the following cycle.
- WAIT_RES: wait_cnt increments each cycle.
  - cnn_valid=1: capture cnn_decision into result, pulse result_valid for 1 cycle, go to DONE.
  - wait_cnt == TIMEOUT-1 without cnn_valid: result=4'hF, timeout_err=1, pulse result_valid, go to DONE.
  - cnn_valid on the same cycle as the timeout: the decision wins and timeout_err stays 0.
- DONE: ready=1. start=1 behaves as in IDLE (restream). result and timeout_err hold until the next start.
- ready=1 only in IDLE and DONE. start while ready=0 is ignored (no queuing).
- Writes:
  - Accepted only when ready=1 and wr_addr < IMG_W*IMG_H.
  - Writes during STREAM/WAIT_RES, or out-of-range writes, are dropped silently so the frame cannot be corrupted mid-stream.
  - A write and a start in the same cycle: the write is accepted and streaming starts. Because RAM is write-first, that address reads the new value.
- cnn_valid in IDLE, STREAM or DONE sets proto_err and is otherwise ignored.
- Counter widths: pix_cnt ADDR_BITS; gap_cnt clog2(GAP_CYCLES+1) (minimum 1); wait_cnt clog2(TIMEOUT+1). None of them wrap: each terminates through an FSM transition.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - state encoding constants (IDLE=0, STREAM=1, WAIT_RES=2, DONE=3);
  - FRAME_PIXELS = IMG_W*IMG_H;
  - RESULT_TIMEOUT_CODE = 4'hF;
  - DECISION_BITS = 4.
- One sub-module, frame_ram_sp: single-port synchronous write-first RAM, DATA_BITS x 2^ADDR_BITS. Write and read are muxed on one address: write when accepted, else read pix_cnt.

Test Plan:
1. Load pixel[i] = i mod 256 at addresses 0..783, then pulse start. Require pixel_valid high on 784 consecutive cycles starting 2 cycles after start, with pixel_out sequence 0,1,...,255,0,... and ready=0 throughout.
2. GAP_CYCLES=2, same frame. Require the valid pattern 1,0,0 repeated, with 784 valid pixels in order over 2352 cycles.
3. Model the CNN returning cnn_valid=1, decision=4'd7, 500 cycles after the last pixel. Require result_valid pulsed once, result=7, timeout_err=0, ready=1.
4. TIMEOUT=64 and no cnn_valid. Require result=4'hF and timeout_err=1 exactly 64 cycles after entering WAIT_RES. Then cnn_valid with decision 3 arrives in DONE: require proto_err=1 and result unchanged.
5. During STREAM, write 8'hAA to address 0 and pulse start. Require both ignored. Restream after DONE and require pixel 0 to still be 0.
6. Assert rst at pixel 400. Require pixel_valid=0 and ready=0 the next cycle, with all outputs 0 after reset. A new start streams from address 0 with the RAM data intact.
